// File: rtl/mux16_1_reg.sv
// Registered 16:1 lane selector built as a 4-level tree of 2:1 cells.
// Define MUX16_1_PIPE_EN to add a pipeline stage between tree levels 1 and 2 (latency 2).
module mux16_1_reg #(
    parameter int unsigned WIDTH = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic [3:0]          sel,
    input  logic [16*WIDTH-1:0] in,
    output logic [WIDTH-1:0]    out,
    output logic                out_valid
);

    logic [WIDTH-1:0] lvl0     [8];
    logic [WIDTH-1:0] lvl1     [4];
    logic [WIDTH-1:0] stg_lvl1 [4];
    logic [1:0]       stg_sel;
    logic             stg_en;
    logic [WIDTH-1:0] lvl2     [2];
    logic [WIDTH-1:0] lvl3;

    // Levels 0 and 1: pairs (2j, 2j+1) steered by sel[0], then sel[1].
    always_comb begin
        for (int j = 0; j < 8; j++) begin
            lvl0[j] = sel[0] ? in[(2*j+1)*WIDTH +: WIDTH] : in[(2*j)*WIDTH +: WIDTH];
        end
        for (int j = 0; j < 4; j++) begin
            lvl1[j] = sel[1] ? lvl0[2*j+1] : lvl0[2*j];
        end
    end

`ifdef MUX16_1_PIPE_EN
    // Stage always loads; the staged enable carries bubbles to the output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < 4; j++) begin
                stg_lvl1[j] <= '0;
            end
            stg_sel <= 2'b00;
            stg_en  <= 1'b0;
        end else begin
            for (int j = 0; j < 4; j++) begin
                stg_lvl1[j] <= lvl1[j];
            end
            stg_sel <= sel[3:2];
            stg_en  <= en;
        end
    end
`else
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            stg_lvl1[j] = lvl1[j];
        end
        stg_sel = sel[3:2];
        stg_en  = en;
    end
`endif

    // Levels 2 and 3 use the (possibly staged) upper select bits.
    always_comb begin
        for (int j = 0; j < 2; j++) begin
            lvl2[j] = stg_sel[0] ? stg_lvl1[2*j+1] : stg_lvl1[2*j];
        end
        lvl3 = stg_sel[1] ? lvl2[1] : lvl2[0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else if (stg_en) begin
            out       <= lvl3;
            out_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mux16_1_reg.sv
// Bench for mux16_1_reg: WIDTH=4 and WIDTH=1 instances share control, scoreboard-checked.
module tb_mux16_1_reg;

`ifdef MUX16_1_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic       en;
        logic [3:0] v4;
        logic       v1;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [63:0] in4 = '0;
    logic [15:0] in1 = '0;
    logic [3:0]  out4;
    logic        valid4;
    logic [0:0]  out1;
    logic        valid1;

    exp_t        sb[$];
    logic [3:0]  exp4;
    logic        exp1;
    logic        expv;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    mux16_1_reg #(.WIDTH(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .en(en), .sel(sel), .in(in4),
        .out(out4), .out_valid(valid4)
    );

    mux16_1_reg #(.WIDTH(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .en(en), .sel(sel), .in(in1),
        .out(out1), .out_valid(valid1)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        exp4 = 4'h0;
        exp1 = 1'b0;
        expv = 1'b0;
    endtask

    // Drive one cycle, push the prediction, then pop/compare once it is due at the output.
    task automatic step(input logic e, input logic [3:0] s, input logic [63:0] i4,
                        input logic [15:0] i1, input string tag);
        exp_t ent;
        @(negedge clk);
        en  = e;
        sel = s;
        in4 = i4;
        in1 = i1;
        ent.en = e;
        ent.v4 = i4[s*4 +: 4];
        ent.v1 = i1[s];
        sb.push_back(ent);
        @(posedge clk);
        #1;
        if (sb.size() >= LAT) begin
            ent = sb.pop_front();
            if (ent.en) begin
                exp4 = ent.v4;
                exp1 = ent.v1;
                expv = 1'b1;
            end
        end
        chk({tag, ".out4"}, {4'h0, out4}, {4'h0, exp4});
        chk({tag, ".valid4"}, {7'h0, valid4}, {7'h0, expv});
        chk({tag, ".out1"}, {7'h0, out1}, {7'h0, exp1});
        chk({tag, ".valid1"}, {7'h0, valid1}, {7'h0, expv});
    endtask

    function automatic logic [63:0] lanes_k();
        logic [63:0] v;
        for (int k = 0; k < 16; k++) v[k*4 +: 4] = 4'(k);
        return v;
    endfunction

    initial begin
        logic [63:0] v4;
        logic [15:0] v1;
        model_reset();

        // Reset held across edges.
        repeat (2) @(posedge clk);
        #1;
        chk("reset.out4", {4'h0, out4}, 8'h00);
        chk("reset.valid4", {7'h0, valid4}, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;

        // First edge after release with en=0 must not capture.
        step(1'b0, 4'h5, lanes_k(), 16'hffff, "noen");
        chk("noen.valid", {7'h0, valid4}, 8'h00);

        // Lane ordering, WIDTH=4 lane k = k; WIDTH=1 in=8000.
        for (int k = 0; k < 16; k++) step(1'b1, 4'(k), lanes_k(), 16'h8000, "order");
        for (int k = 0; k < LAT; k++) step(1'b1, 4'd9, lanes_k(), 16'h8000, "order9");
        chk("order.sel9", {4'h0, out4}, 8'h09);

        // Random WIDTH=1 patterns across every select.
        for (int p = 0; p < 24; p++) begin
            v1 = 16'($urandom);
            v4 = {$urandom, $urandom};
            for (int s = 0; s < 16; s++) step(1'b1, 4'(s), v4, v1, "rand");
        end

        // Hold: capture lane3=A, then en=0 with scrambled inputs.
        v4 = lanes_k();
        v4[12 +: 4] = 4'hA;
        step(1'b1, 4'd3, v4, 16'h0008, "holdcap");
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 4'($urandom), {$urandom, $urandom}, 16'($urandom), "hold");
        end
        chk("hold.final", {4'h0, out4}, 8'h0A);

        // Simultaneous sel and data change.
        v4 = lanes_k();
        v4[20 +: 4] = 4'h1;
        for (int k = 0; k < LAT + 1; k++) step(1'b1, 4'd2, v4, 16'h0, "sim_pre");
        v4[20 +: 4] = 4'h7;
        step(1'b1, 4'd5, v4, 16'h0020, "sim");
        for (int k = 1; k < LAT; k++) step(1'b1, 4'd5, v4, 16'h0020, "sim_fill");
        chk("sim.out", {4'h0, out4}, 8'h07);

        // Mid-cycle asynchronous reset with out=1 valid=1.
        v4 = '0;
        v4[4 +: 4] = 4'h1;
        for (int k = 0; k < LAT + 1; k++) step(1'b1, 4'd1, v4, 16'h0002, "prerst");
        #2;
        reset_n = 1'b0;
        #1;
        chk("async.out4", {4'h0, out4}, 8'h00);
        chk("async.valid4", {7'h0, valid4}, 8'h00);
        chk("async.out1", {7'h0, out1}, 8'h00);
        model_reset();
        en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // Post-reset fill: sel=6 lane6=C; valid appears LAT enabled edges later.
        v4 = lanes_k();
        v4[24 +: 4] = 4'hC;
        step(1'b1, 4'd6, v4, 16'h0040, "fill1");
        step(1'b1, 4'd6, v4, 16'h0040, "fill2");
        chk("fill.out", {4'h0, out4}, 8'h0C);
        step(1'b1, 4'd0, v4, 16'h0001, "fill3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1);
    end

endmodule
